// File: rtl/letc_core_limp_arbiter.sv
// Round-robin arbiter sharing the core's single LIMP port among NUM_REQ requesters.
// Define LETC_LIMP_ARB_PERF_CNT_EN to add per-requester completed-transaction counters (o_grant_cnt).
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters, starting after last_idx
// BUSY  | grant_idx owns the downstream port until i_ready
module letc_core_limp_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [NUM_REQ-1:0]                i_req_wen_nren,
  input  logic [NUM_REQ-1:0][1:0]           i_req_size,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]                o_req_ready,
  output logic [DATA_W-1:0]                 o_req_rdata,
  output logic                              o_valid,
  output logic                              o_wen_nren,
  output logic [1:0]                        o_size,
  output logic [ADDR_W-1:0]                 o_addr,
  output logic [DATA_W-1:0]                 o_wdata,
  input  logic                              i_ready,
  input  logic [DATA_W-1:0]                 i_rdata,
`ifdef LETC_LIMP_ARB_PERF_CNT_EN
  output logic [NUM_REQ-1:0][31:0]          o_grant_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0]        o_grant_idx,
  output logic                              o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic             active;

  // Walk upward from last_idx+1 with an explicit wrap so non-power-of-2 counts never index past NUM_REQ-1.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = last_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= LAST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (i_ready) begin
            last_idx <= grant_idx;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with i_rst_n keeps the handshake outputs quiet for the whole reset cycle.
  assign active      = (state == BUSY) && i_rst_n;
  assign o_valid     = active;
  assign o_busy      = active;
  assign o_grant_idx = active ? grant_idx : '0;
  assign o_wen_nren  = i_req_wen_nren[grant_idx];
  assign o_size      = i_req_size[grant_idx];
  assign o_addr      = i_req_addr[grant_idx];
  assign o_wdata     = i_req_wdata[grant_idx];
  assign o_req_rdata = i_rdata;

  always_comb begin
    o_req_ready = '0;
    if (active) o_req_ready[grant_idx] = i_ready;
  end

`ifdef LETC_LIMP_ARB_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_grant_cnt <= '0;
    end else if ((state == BUSY) && i_ready) begin
      o_grant_cnt[grant_idx] <= o_grant_cnt[grant_idx] + 32'd1;
    end
  end
`endif

  a_ready_in_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == IDLE) |-> !i_ready);

  a_owner_holds_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == BUSY) |-> i_req_valid[grant_idx]);

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Bench for letc_core_limp_arbiter: directed scenarios plus random LIMP traffic against a transaction model.
module tb_letc_core_limp_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_wen = '0;
  logic [N-1:0][1:0]    req_size = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]         o_req_ready;
  logic [DW-1:0]        o_req_rdata;
  logic                 o_valid, o_wen_nren, o_busy;
  logic [1:0]           o_size;
  logic [AW-1:0]        o_addr;
  logic [DW-1:0]        o_wdata;
  logic                 ready = 1'b0;
  logic [DW-1:0]        rdata = '0;
  logic [1:0]           o_grant_idx;
`ifdef LETC_LIMP_ARB_PERF_CNT_EN
  logic [N-1:0][31:0]   o_grant_cnt;
`endif

  letc_core_limp_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_wen_nren(req_wen), .i_req_size(req_size),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(o_req_ready), .o_req_rdata(o_req_rdata),
    .o_valid(o_valid), .o_wen_nren(o_wen_nren), .o_size(o_size),
    .o_addr(o_addr), .o_wdata(o_wdata),
    .i_ready(ready), .i_rdata(rdata),
`ifdef LETC_LIMP_ARB_PERF_CNT_EN
    .o_grant_cnt(o_grant_cnt),
`endif
    .o_grant_idx(o_grant_idx), .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: owner, last owner, completion counts.
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_last = N - 1;
  int          wait_cnt = 0;
  int unsigned m_cnt[N];
  int          cyc = 0;

  int          req_prob = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          fix_rd = 0;
  logic [31:0] fix_rd_val = '0;
  logic [N-1:0] drop_mask = '0;

  logic [N-1:0] cap_rdy;
  logic [31:0]  cap_rdata;
  bit           prev_v = 0;
  int           dut_log[$];
  int           dut_cyc[$];

  task automatic raise(input int i, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_wen[i]   = w;
    req_size[i]  = s;
    req_addr[i]  = a;
    req_wdata[i] = d;
    drop_mask[i] = 1'b0;
  endtask

  task automatic cycle();
    logic        exp_v;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
    for (int i = 0; i < N; i++)
      if (!req_valid[i] && int'($urandom_range(99, 0)) < req_prob)
        raise(i, 1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), $urandom, $urandom);
    ready = 1'b0;
    if (m_busy && rst_n) begin
      if (wait_cnt == 0) begin
        ready = 1'b1;
        rdata = fix_rd ? fix_rd_val : $urandom;
      end else begin
        wait_cnt--;
      end
    end
    #1;
    exp_v   = m_busy && rst_n;
    exp_rdy = (exp_v && ready) ? N'(1 << m_owner) : '0;
    chk("valid", o_valid, exp_v);
    chk("busy", o_busy, exp_v);
    chk("grant_idx", o_grant_idx, exp_v ? m_owner : 0);
    chk("req_ready", o_req_ready, exp_rdy);
    if (exp_v) begin
      chk("addr", o_addr, req_addr[m_owner]);
      chk("wdata", o_wdata, req_wdata[m_owner]);
      chk("size", o_size, req_size[m_owner]);
      chk("wen", o_wen_nren, req_wen[m_owner]);
    end
    if (exp_rdy != '0) begin
      chk("rdata", o_req_rdata, rdata);
      cap_rdy   = o_req_ready;
      cap_rdata = o_req_rdata;
    end
    if (o_valid && !prev_v) begin
      dut_log.push_back(int'(o_grant_idx));
      dut_cyc.push_back(cyc);
    end
    prev_v = o_valid;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      drop_mask = '1;
    end else if (m_busy) begin
      if (ready) begin
        m_busy = 0;
        m_last = m_owner;
        m_cnt[m_owner]++;
        drop_mask[m_owner] = 1'b1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!m_busy && req_valid[c]) begin
          m_busy   = 1;
          m_owner  = c;
          wait_cnt = int'($urandom_range(lat_max, lat_min));
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    dut_log.delete();
    dut_cyc.delete();
  endtask

  task automatic drain(input int n);
    req_prob = 0;
    repeat (n) cycle();
  endtask

  initial begin
    // Idle after reset
    do_reset();
    repeat (5) cycle();

    // Single read from req1 with 3-cycle downstream latency
    fix_rd = 1; fix_rd_val = 32'hDEAD_BEEF;
    lat_min = 3; lat_max = 3;
    cap_rdy = '0; cap_rdata = '0;
    raise(1, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
    cycle();
    chk("t2_valid", o_valid, 1'b1);
    chk("t2_addr", o_addr, 32'h8000_0010);
    repeat (4) cycle();
    chk("t2_idle", o_busy, 1'b0);
    chk("t2_rdy", cap_rdy, 3'b010);
    chk("t2_rdata", cap_rdata, 32'hDEAD_BEEF);
    fix_rd = 0;
    drain(4);

    // All three requesting continuously from reset
    do_reset();
    lat_min = 0; lat_max = 0;
    req_prob = 100;
    repeat (14) cycle();
    drain(12);
    for (int k = 0; k < 6; k++) begin
      chk("t3_order", (k < dut_log.size()) ? dut_log[k] : -1, k % 3);
      if (k > 0)
        chk("t3_bubble", (k < dut_cyc.size()) ? dut_cyc[k] - dut_cyc[k-1] : -1, 2);
    end

    // req0 arrives while req2's write is in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    raise(2, 1'b1, 2'd2, 32'h0000_4000, 32'h1234_5678);
    cycle();
    chk("t4_wdata0", o_wdata, 32'h1234_5678);
    raise(0, 1'b0, 2'd1, 32'h0000_0100, 32'h0);
    repeat (3) cycle();
    chk("t4_owner", o_grant_idx, 2'd2);
    chk("t4_wdata3", o_wdata, 32'h1234_5678);
    drain(12);
    chk("t4_first", (dut_log.size() > 0) ? dut_log[0] : -1, 2);
    chk("t4_second", (dut_log.size() > 1) ? dut_log[1] : -1, 0);

    // Reset in the middle of a transaction
    do_reset();
    lat_min = 5; lat_max = 5;
    raise(1, 1'b0, 2'd2, 32'h0000_0200, 32'h0);
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_valid", o_valid, 1'b0);
    dut_log.delete();
    dut_cyc.delete();
    lat_min = 0; lat_max = 0;
    raise(0, 1'b0, 2'd2, 32'h0000_0300, 32'h0);
    raise(1, 1'b1, 2'd0, 32'h0000_0304, 32'hA5A5_A5A5);
    drain(10);
    chk("t5_next", (dut_log.size() > 0) ? dut_log[0] : -1, 0);

    // 4 transactions from req1, 2 from req2
    do_reset();
    lat_min = 0; lat_max = 2;
    for (int t = 0; t < 4; t++) begin
      raise(1, 1'($urandom_range(1, 0)), 2'd2, $urandom, $urandom);
      repeat (6) cycle();
    end
    for (int t = 0; t < 2; t++) begin
      raise(2, 1'($urandom_range(1, 0)), 2'd2, $urandom, $urandom);
      repeat (6) cycle();
    end
`ifdef LETC_LIMP_ARB_PERF_CNT_EN
    chk("perf_cnt", o_grant_cnt, {32'd2, 32'd4, 32'd0});
`endif

    // Random traffic
    do_reset();
    req_prob = 30;
    lat_min = 0; lat_max = 3;
    repeat (3000) cycle();
    drain(10);
`ifdef LETC_LIMP_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) chk("rand_cnt", o_grant_cnt[i], m_cnt[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
